// File: rtl/alu_arbiter_pkg.sv
// Shared encodings for alu_arbiter: ALU op codes, FSM states, port ids.
// Op codes 5'h00..5'h10 are defined; every other 5-bit value is illegal.
package alu_arbiter_pkg;

  localparam logic [4:0] ALUOP_NOP  = 5'h00;
  localparam logic [4:0] ALUOP_ADDU = 5'h01;
  localparam logic [4:0] ALUOP_ADD  = 5'h02;
  localparam logic [4:0] ALUOP_SUBU = 5'h03;
  localparam logic [4:0] ALUOP_SUB  = 5'h04;
  localparam logic [4:0] ALUOP_AND  = 5'h05;
  localparam logic [4:0] ALUOP_OR   = 5'h06;
  localparam logic [4:0] ALUOP_NOR  = 5'h07;
  localparam logic [4:0] ALUOP_XOR  = 5'h08;
  localparam logic [4:0] ALUOP_SLT  = 5'h09;
  localparam logic [4:0] ALUOP_SLTU = 5'h0A;
  localparam logic [4:0] ALUOP_EQL  = 5'h0B;
  localparam logic [4:0] ALUOP_BNE  = 5'h0C;
  localparam logic [4:0] ALUOP_SLL  = 5'h0D;
  localparam logic [4:0] ALUOP_SRL  = 5'h0E;
  localparam logic [4:0] ALUOP_SRA  = 5'h0F;
  localparam logic [4:0] ALUOP_LUI  = 5'h10;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  function automatic logic op_defined(input logic [4:0] op);
    return op <= ALUOP_LUI;
  endfunction

  // Compare ops report their outcome through the zero flag, not the result.
  function automatic logic op_is_cmp(input logic [4:0] op);
    return (op == ALUOP_EQL) || (op == ALUOP_BNE);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU. zero carries the branch condition for EQL/BNE:
// EQL -> a == b, BNE -> a != b; it is low for all other ops.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  op,
  output logic [31:0] c,
  output logic        zero
);

  always_comb begin
    c    = 32'd0;
    zero = 1'b0;
    case (op)
      ALUOP_NOP:             c = a;
      ALUOP_ADDU, ALUOP_ADD: c = a + b;
      ALUOP_SUBU, ALUOP_SUB: c = a - b;
      ALUOP_AND:             c = a & b;
      ALUOP_OR:              c = a | b;
      ALUOP_NOR:             c = ~(a | b);
      ALUOP_XOR:             c = a ^ b;
      ALUOP_SLT:             c = {31'd0, $signed(a) < $signed(b)};
      ALUOP_SLTU:            c = {31'd0, a < b};
      ALUOP_SLL:             c = a << b[4:0];
      ALUOP_SRL:             c = a >> b[4:0];
      ALUOP_SRA:             c = $unsigned($signed(a) >>> b[4:0]);
      ALUOP_LUI:             c = {b[15:0], 16'h0000};
      ALUOP_EQL: begin
        c    = a - b;
        zero = (a == b);
      end
      ALUOP_BNE: begin
        c    = a - b;
        zero = (a != b);
      end
      default:               c = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single shared ALU: IDLE -> EXEC -> RESP.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int RR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_illegal,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  arb_state_t  state;
  logic        last_grant;
  logic        grant_id;
  logic        accept;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  op_q;
  logic        id_q;
  logic [31:0] alu_c;
  logic        alu_zero;

  assign dbg_state = state;

  // Grant depends only on state and request valids, never on resp_ready.
  always_comb begin
    grant_id = PORT0;
    if (req0_valid && req1_valid)
      grant_id = (RR != 0) ? ~last_grant : PORT0;
    else if (req1_valid)
      grant_id = PORT1;
  end

  assign req0_ready = (state == ST_IDLE) && req0_valid && (grant_id == PORT0);
  assign req1_ready = (state == ST_IDLE) && req1_valid && (grant_id == PORT1);
  assign accept     = (state == ST_IDLE) && (req0_valid || req1_valid);

  alu_arbiter_alu u_alu (
    .a    (a_q),
    .b    (b_q),
    .op   (op_q),
    .c    (alu_c),
    .zero (alu_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_grant   <= PORT1;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      op_q         <= 5'd0;
      id_q         <= PORT0;
      resp_valid   <= 1'b0;
      resp_id      <= PORT0;
      resp_result  <= 32'd0;
      resp_zero    <= 1'b0;
      resp_illegal <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q        <= (grant_id == PORT1) ? req1_a  : req0_a;
            b_q        <= (grant_id == PORT1) ? req1_b  : req0_b;
            op_q       <= (grant_id == PORT1) ? req1_op : req0_op;
            id_q       <= grant_id;
            last_grant <= grant_id;
            busy       <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
          if (!op_defined(op_q)) begin
            resp_result  <= 32'd0;
            resp_zero    <= 1'b0;
            resp_illegal <= 1'b1;
          end else if (op_is_cmp(op_q)) begin
            resp_result  <= 32'd0;
            resp_zero    <= alu_zero;
            resp_illegal <= 1'b0;
          end else begin
            resp_result  <= alu_c;
            resp_zero    <= 1'b0;
            resp_illegal <= 1'b0;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios, then randomized traffic checked
// against a transaction-level model (expected-response queue + grant rule).
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        v [2];
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic [4:0]  op [2];
  logic        resp_ready;

  logic        req0_ready, req1_ready, resp_valid, resp_id, resp_zero, resp_illegal, busy;
  logic [31:0] resp_result;
  logic [1:0]  dbg_state;

  logic        fp_req0_ready, fp_req1_ready, fp_resp_valid, fp_resp_id, fp_resp_zero;
  logic        fp_resp_illegal, fp_busy;
  logic [31:0] fp_resp_result;
  logic [1:0]  fp_dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [34:0] exp_q [$];

  alu_arbiter #(.RR(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_a(a[0]), .req0_b(b[0]), .req0_op(op[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_a(a[1]), .req1_b(b[1]), .req1_op(op[1]),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_illegal(resp_illegal),
    .busy(busy), .dbg_state(dbg_state)
  );

  alu_arbiter #(.RR(0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(fp_req0_ready), .req0_a(a[0]), .req0_b(b[0]), .req0_op(op[0]),
    .req1_valid(v[1]), .req1_ready(fp_req1_ready), .req1_a(a[1]), .req1_b(b[1]), .req1_op(op[1]),
    .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_id(fp_resp_id),
    .resp_result(fp_resp_result), .resp_zero(fp_resp_zero), .resp_illegal(fp_resp_illegal),
    .busy(fp_busy), .dbg_state(fp_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected response word {id, illegal, zero, result} from the op definitions.
  function automatic logic [34:0] model(input logic [4:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic id);
    logic [31:0] r;
    logic        z;
    logic        ill;
    int          sh;
    r = 32'd0; z = 1'b0; ill = 1'b0; sh = int'(y % 32);
    case (o)
      ALUOP_NOP:             r = x;
      ALUOP_ADDU, ALUOP_ADD: r = x + y;
      ALUOP_SUBU, ALUOP_SUB: r = x - y;
      ALUOP_AND:             r = x & y;
      ALUOP_OR:              r = x | y;
      ALUOP_NOR:             r = ~(x | y);
      ALUOP_XOR:             r = x ^ y;
      ALUOP_SLT:             r = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      ALUOP_SLTU:            r = (x < y) ? 32'd1 : 32'd0;
      ALUOP_SLL:             r = x << sh;
      ALUOP_SRL:             r = x >> sh;
      ALUOP_SRA:             r = (x >> sh) | ((x[31] && sh != 0) ? ~(32'hFFFFFFFF >> sh) : 32'd0);
      ALUOP_LUI:             r = y * 32'h10000;
      ALUOP_EQL:             z = (x == y);
      ALUOP_BNE:             z = (x != y);
      default:               ill = 1'b1;
    endcase
    return {id, ill, z, r};
  endfunction

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Presents a request from port p and holds it until granted; returns at the
  // negedge of the cycle after the handshake.
  task automatic issue(input int p, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [4:0] top, input string tag);
    logic got;
    v[p] = 1'b1; a[p] = ta; b[p] = tb_v; op[p] = top;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      #1;
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) got = 1'b1;
      @(negedge clk);
    end
    v[p] = 1'b0;
    chk({tag, "_grant"}, {31'd0, got}, 32'd1);
  endtask

  task automatic run_op(input int p, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [4:0] top, input string tag);
    logic [34:0] e;
    e = model(top, ta, tb_v, p[0]);
    issue(p, ta, tb_v, top, tag);
    #1;
    chk({tag, "_lat_n1"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    #1;
    chk({tag, "_valid_n2"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_result"}, resp_result, e[31:0]);
    chk({tag, "_flags"}, {29'd0, resp_id, resp_illegal, resp_zero}, {29'd0, e[34:32]});
    @(negedge clk);
  endtask

  initial begin : main
    int g_rr, g_fp, cyc;
    logic got, m_last, e_r0, e_r1, g;
    logic took [2];

    rst = 1'b1; resp_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0; a[p] = '0; b[p] = '0; op[p] = '0;
    end

    // reset state
    do_reset();
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_flags", {29'd0, resp_id, resp_illegal, resp_zero}, 32'd0);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(negedge clk);

    // basic ops
    run_op(0, 32'd5, 32'd3, ALUOP_ADDU, "addu");
    run_op(1, 32'd7, 32'd7, ALUOP_EQL, "eql");
    run_op(1, 32'd7, 32'd7, ALUOP_BNE, "bne");
    run_op(0, 32'hFFFFFFFF, 32'd1, ALUOP_SLT, "slt");
    run_op(1, 32'd0, 32'h1234, ALUOP_LUI, "lui");
    run_op(0, 32'd9, 32'd9, 5'h1F, "illegal");

    // response back-pressure
    resp_ready = 1'b0;
    issue(0, 32'd100, 32'd23, ALUOP_ADDU, "stall");
    v[0] = 1'b1; v[1] = 1'b1; a[1] = 32'd1; b[1] = 32'd1; op[1] = ALUOP_ADDU;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_valid", {31'd0, resp_valid}, 32'd1);
      chk("stall_result", resp_result, 32'd123);
      chk("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    chk("release_result", resp_result, 32'd123);
    @(negedge clk);
    #1;
    chk("post_drain_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
    @(negedge clk);
    v[0] = 1'b0; v[1] = 1'b0;
    run_op(0, 32'd1, 32'd2, ALUOP_ADDU, "after_stall");

    // reset during EXEC
    issue(0, 32'd4, 32'd4, ALUOP_ADDU, "rst_exec");
    rst = 1'b1;
    #1;
    chk("rst_exec_busy", {31'd0, busy}, 32'd0);
    chk("rst_exec_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_exec_noresp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    run_op(1, 32'd10, 32'd20, ALUOP_ADDU, "rst_recover");

    // both ports requesting continuously: RR alternates, fixed priority stays on 0
    do_reset();
    v[0] = 1'b1; a[0] = 32'd1; b[0] = 32'd1; op[0] = ALUOP_ADDU;
    v[1] = 1'b1; a[1] = 32'd2; b[1] = 32'd2; op[1] = ALUOP_ADDU;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0; g_rr = -1; g_fp = -1;
      for (int t = 0; t < 10 && !got; t++) begin
        #1;
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          g_rr = req1_ready ? 1 : 0;
          g_fp = fp_req1_ready ? 1 : (fp_req0_ready ? 0 : -1);
        end
        @(negedge clk);
      end
      chk("rr_grant", g_rr, k % 2);
      chk("fp_grant", g_fp, 0);
    end
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (3) @(negedge clk);

    // randomized traffic against the transaction model
    do_reset();
    cyc = -1; m_last = 1'b1; took[0] = 1'b0; took[1] = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (took[p]) v[p] = 1'b0;
        took[p] = 1'b0;
        if (!v[p] && $urandom_range(0, 2) == 0) begin
          v[p] = 1'b1;
          a[p] = $urandom;
          b[p] = ($urandom_range(0, 3) == 0) ? a[p] : $urandom;
          op[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e_r0 = (cyc < 0) && v[0] && (!v[1] || m_last == 1'b1);
      e_r1 = (cyc < 0) && v[1] && (!v[0] || m_last == 1'b0);
      chk("rnd_ready", {30'd0, req1_ready, req0_ready}, {30'd0, e_r1, e_r0});
      chk("rnd_busy", {31'd0, busy}, {31'd0, cyc >= 0});
      chk("rnd_valid", {31'd0, resp_valid}, {31'd0, cyc >= 2});
      if (cyc >= 2) begin
        chk("rnd_result", resp_result, exp_q[0][31:0]);
        chk("rnd_flags", {29'd0, resp_id, resp_illegal, resp_zero}, {29'd0, exp_q[0][34:32]});
      end
      if (e_r0 || e_r1) begin
        g = e_r1;
        exp_q.push_back(model(op[g], a[g], b[g], g));
        m_last = g;
        took[g] = 1'b1;
        cyc = 1;
      end else if (cyc >= 2 && resp_ready) begin
        void'(exp_q.pop_front());
        cyc = -1;
      end else if (cyc >= 1) begin
        cyc++;
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
